// File: rtl/lbm_relax_stage.sv
// BGK relaxation of one LBM distribution value, f_out = f + omega*(feq - f),
// as a 3-stage lock-step valid/ready pipeline with a saturating output.
module lbm_relax_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_BITS  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] f_in,
  input  logic [DATA_WIDTH-1:0] feq_in,
  input  logic [FRAC_BITS:0]    omega,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] f_out,
  output logic                  sat_flag,
  output logic [CNT_WIDTH-1:0]  sample_cnt
);

  // Handshake: a word moves across a port on a rising edge where valid && ready.
  // valid never waits on ready; while valid && !ready the word is held unchanged.
  // in_ready is combinational from out_valid/out_ready (no internal skid buffer).

  localparam int DW = DATA_WIDTH;
  localparam int FB = FRAC_BITS;
  localparam int PW = DW + FB + 2;   // product width, signed
  localparam int RW = DW + 2;        // rounded product width after dropping FB bits
  localparam int SW = DW + 3;        // sum width, cannot overflow

  localparam logic [PW-1:0]        RND     = {{(PW-FB){1'b0}}, 1'b1, {(FB-1){1'b0}}};
  localparam logic [DW-1:0]        MAX_POS = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        MIN_NEG = {1'b1, {(DW-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  // Pipeline advance: the whole pipe moves as one, so a stall anywhere freezes all stages.
  logic adv;
  logic out_fire;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign out_fire = out_valid && out_ready;

  // ---------------------------------------------------------------------------
  // Stage 1: capture f and omega, form feq - f one bit wider than the data.
  // ---------------------------------------------------------------------------
  logic          s1_valid;
  logic [DW-1:0] s1_f;
  logic [FB:0]   s1_omega;
  logic [DW:0]   s1_diff;
  logic [DW:0]   diff_c;

  assign diff_c = {feq_in[DW-1], feq_in} - {f_in[DW-1], f_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_f     <= '0;
      s1_omega <= '0;
      s1_diff  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_f     <= f_in;
        s1_omega <= omega;
        s1_diff  <= diff_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: diff * omega, round half toward +inf, drop the fractional bits.
  // ---------------------------------------------------------------------------
  logic          s2_valid;
  logic [DW-1:0] s2_f;
  logic [RW-1:0] s2_prod;
  logic [PW-1:0] diff_x;
  logic [PW-1:0] omega_x;
  logic [PW-1:0] prod_c;
  logic [PW-1:0] rnd_c;
  logic          unused_rnd_bits;

  // diff is sign-extended, omega is unsigned so it is zero-extended; the low PW
  // bits of the product are exact because the true product fits in PW bits.
  assign diff_x  = {{(PW-DW-1){s1_diff[DW]}}, s1_diff};
  assign omega_x = {{(PW-FB-1){1'b0}}, s1_omega};
  assign prod_c  = diff_x * omega_x;
  assign rnd_c   = prod_c + RND;
  assign unused_rnd_bits = ^rnd_c[FB-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_f     <= '0;
      s2_prod  <= '0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_f    <= s1_f;
        s2_prod <= rnd_c[PW-1:FB];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: f + prod, clamp to the representable range.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] sum_c;
  logic          ovf_c;
  logic [DW-1:0] sat_c;

  assign sum_c = {{(SW-DW){s2_f[DW-1]}}, s2_f} + {{(SW-RW){s2_prod[RW-1]}}, s2_prod};

  // Out of range whenever the bits above the result's sign bit disagree with the true sign.
  assign ovf_c = (sum_c[SW-1:DW-1] != {(SW-DW+1){sum_c[SW-1]}});

  always_comb begin
    sat_c = sum_c[DW-1:0];
    if (ovf_c) begin
      sat_c = sum_c[SW-1] ? MIN_NEG : MAX_POS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f_out     <= '0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        f_out <= sat_c;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Status: sticky saturation flag and free-running transfer counter.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
    end else if (adv && s2_valid && ovf_c) begin
      sat_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
    end else if (out_fire) begin
      sample_cnt <= sample_cnt + CNT_ONE;
    end
  end

endmodule
